// File: rtl/buff_uart_pkg.sv
// Shared types for the buffered UART: parity selection, TX/RX FSM states and status word bit positions.
package buff_uart_pkg;

   typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;

   localparam int ST_RX_NOT_EMPTY = 0;
   localparam int ST_RX_FULL      = 1;
   localparam int ST_TX_EMPTY     = 2;
   localparam int ST_TX_FULL      = 3;
   localparam int ST_TX_BUSY      = 4;
   localparam int ST_RX_OVERRUN   = 5;
   localparam int ST_TX_OVERFLOW  = 6;
   localparam int ST_FRAME_ERR    = 7;
   localparam int ST_PARITY_ERR   = 8;

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead FIFO: rdata is the head entry with no read latency; push and pop take effect on the clock edge.
// Push into a full FIFO is ignored unless a pop happens in the same cycle; pop on empty is ignored.
module uart_fifo #(
   parameter int width = 8,
   parameter int depth = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [width-1:0]         wdata,
   input  logic                     pop,
   output logic [width-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);
   localparam int AW = $clog2(depth);

   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [width-1:0] mem_q [depth];
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit: equal means empty, differing only in the wrap bit means full.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count   = wr_ptr_q - rd_ptr_q;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/buff_uart_ctrl.sv
// Register-mapped full-duplex UART with independent RX/TX FIFOs, parity, sticky errors and a level irq.
// rdata lands one clock after a read strobe; no backpressure - writes to a full TX FIFO and frames into a full RX FIFO are dropped and flagged.
module buff_uart_ctrl
   import buff_uart_pkg::*;
#(
   parameter int      width         = 8,
   parameter int      rx_depth      = 4,
   parameter int      tx_depth      = 4,
   parameter int      address_width = 4,
   parameter int      rx_address    = 0,
   parameter int      tx_address    = 1,
   parameter int      stat_address  = 2,
   parameter parity_e parity_mode   = PAR_NONE,
   parameter int      stop_bits     = 1,
   parameter int      baud_rate     = 9600,
   parameter int      clock_freq    = 460800
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rx,
   output logic                     tx,
   input  logic [address_width-1:0] active_address,
   input  logic                     read_enable,
   input  logic                     write_enable,
   input  logic [width-1:0]         wdata,
   output logic [width-1:0]         rdata,
   output logic                     irq
);
   localparam int DIV  = clock_freq / baud_rate;
   localparam int CW   = $clog2(DIV);
   localparam int BW   = $clog2(width);
   localparam int RXAW = $clog2(rx_depth);
   localparam int TXAW = $clog2(tx_depth);
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] DIV_HALF  = CW'(DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(stop_bits - 1);

   if (DIV < 4 || DIV * baud_rate != clock_freq) begin : g_bad_div
      $error("buff_uart_ctrl: clock_freq/baud_rate must be an integer >= 4");
   end
   if (width < 5 || width > 9 || stop_bits < 1 || stop_bits > 2) begin : g_bad_frame
      $error("buff_uart_ctrl: width must be 5..9 and stop_bits 1 or 2");
   end
   if (rx_depth < 2 || tx_depth < 2 || (1 << RXAW) != rx_depth || (1 << TXAW) != tx_depth) begin : g_bad_depth
      $error("buff_uart_ctrl: FIFO depths must be powers of 2, >= 2");
   end

   logic rd_rx, rd_stat, wr_tx;
   assign rd_rx   = read_enable  && (active_address == address_width'(rx_address));
   assign rd_stat = read_enable  && (active_address == address_width'(stat_address));
   assign wr_tx   = write_enable && (active_address == address_width'(tx_address));

   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic             tx_pop, tx_full, tx_empty;
   logic [width-1:0] rx_head, tx_head, rx_shift_q, rx_shift_d;
   logic [RXAW:0]    rx_count;
   logic [TXAW:0]    tx_count;

   assign rx_pop = rd_rx && !rx_empty;

   uart_fifo #(.width(width), .depth(rx_depth)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_shift_q), .pop(rx_pop),
      .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count));

   uart_fifo #(.width(width), .depth(tx_depth)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push(wr_tx), .wdata(wdata), .pop(tx_pop),
      .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count));

   // ---------------- transmitter ----------------
   tx_state_e        tx_state_q, tx_state_d;
   logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]    tx_bit_q, tx_bit_d;
   logic [width-1:0] tx_shift_q, tx_shift_d;
   logic             tx_par_q, tx_par_d;
   logic             tx_bit_end;

   assign tx_bit_end = (tx_cnt_q == DIV_LAST);

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_pop     = 1'b0;
      tx         = 1'b1;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_par_d   = ^tx_head ^ (parity_mode == PAR_ODD);
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            tx = 1'b0;
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            tx = tx_shift_q[0];
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_shift_d = tx_shift_q >> 1;
               if (tx_bit_q == BIT_LAST) begin
                  tx_bit_d   = '0;
                  tx_state_d = (parity_mode == PAR_NONE) ? TX_STOP : TX_PARITY;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
         TX_PARITY: begin
            tx = tx_par_q;
            if (tx_bit_end) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               if (tx_bit_q == STOP_LAST) begin
                  tx_bit_d   = '0;
                  tx_state_d = TX_IDLE;
                  // Chain straight into the next start bit so buffered frames leave without an idle gap.
                  if (!tx_empty) begin
                     tx_pop     = 1'b1;
                     tx_shift_d = tx_head;
                     tx_par_d   = ^tx_head ^ (parity_mode == PAR_ODD);
                     tx_state_d = TX_START;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // ---------------- receiver ----------------
   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [BW-1:0] rx_bit_q, rx_bit_d;
   logic          rx_par_q, rx_par_d;
   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   logic          frame_set, parity_set, overrun_set;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + 1'b1;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_par_d    = rx_par_q;
      rx_push     = 1'b0;
      frame_set   = 1'b0;
      parity_set  = 1'b0;
      overrun_set = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == DIV_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[width-1:1]};
               if (rx_bit_q == BIT_LAST) begin
                  rx_state_d = (parity_mode == PAR_NONE) ? RX_STOP : RX_PARITY;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d   = '0;
               rx_par_d   = rx_s2_q;
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               if (!rx_s2_q) begin
                  frame_set  = 1'b1;
                  rx_state_d = RX_BREAK;
               end else if (parity_mode != PAR_NONE &&
                            ((^rx_shift_q ^ rx_par_q) != (parity_mode == PAR_ODD))) begin
                  parity_set = 1'b1;
               end else begin
                  rx_push     = 1'b1;
                  overrun_set = rx_full && !rx_pop;
               end
            end
         end
         RX_BREAK: begin
            rx_cnt_d = '0;
            if (rx_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- host side ----------------
   logic [3:0]       sticky_q, sticky_d;
   logic [8:0]       stat_v;
   logic [width-1:0] rdata_q, rdata_d;

   // A flag raised in the cycle of a status read survives the clear.
   assign sticky_d = ({parity_set, frame_set, wr_tx && tx_full && !tx_pop, overrun_set})
                     | (rd_stat ? 4'b0 : sticky_q);

   always_comb begin
      stat_v                  = '0;
      stat_v[ST_RX_NOT_EMPTY] = !rx_empty;
      stat_v[ST_RX_FULL]      = (rx_count == (RXAW + 1)'(rx_depth));
      stat_v[ST_TX_EMPTY]     = tx_empty;
      stat_v[ST_TX_FULL]      = (tx_count == (TXAW + 1)'(tx_depth));
      stat_v[ST_TX_BUSY]      = (tx_state_q != TX_IDLE);
      stat_v[ST_RX_OVERRUN]   = sticky_q[0];
      stat_v[ST_TX_OVERFLOW]  = sticky_q[1];
      stat_v[ST_FRAME_ERR]    = sticky_q[2];
      stat_v[ST_PARITY_ERR]   = sticky_q[3];
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_rx)        rdata_d = rx_empty ? '0 : rx_head;
      else if (rd_stat) rdata_d = width'(stat_v);
   end

   assign rdata = rdata_q;
   assign irq   = !rx_empty || (|sticky_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         sticky_q   <= '0;
         rdata_q    <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         sticky_q   <= sticky_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_buff_uart_ctrl.sv
// Directed bench for buff_uart_ctrl: default 8N1 instance (a) and a 9-bit even-parity instance (b).
// Inputs change and outputs are sampled 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_buff_uart_ctrl;
   import buff_uart_pkg::*;

   localparam int DIV   = 48;
   localparam int FRAME = 10 * DIV;
   localparam logic [3:0] A_RX = 4'd0, A_TX = 4'd1, A_ST = 4'd2;

   logic       clk, rst_n;
   logic       rx_a, tx_a, re_a, we_a, irq_a;
   logic [3:0] addr_a;
   logic [7:0] wd_a, rd_a;
   logic       rx_b, tx_b, re_b, we_b, irq_b;
   logic [3:0] addr_b;
   logic [8:0] wd_b, rd_b;

   int n_checks;
   int n_errors;
   logic [7:0] exp_bytes [5];
   logic [8:0] rv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   buff_uart_ctrl u_dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .tx(tx_a), .active_address(addr_a),
      .read_enable(re_a), .write_enable(we_a), .wdata(wd_a), .rdata(rd_a), .irq(irq_a));

   buff_uart_ctrl #(.width(9), .parity_mode(PAR_EVEN)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .tx(tx_b), .active_address(addr_b),
      .read_enable(re_b), .write_enable(we_b), .wdata(wd_b), .rdata(rd_b), .irq(irq_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic host_write(input bit sel, input logic [3:0] addr, input logic [8:0] data);
      if (sel) begin addr_b = addr; wd_b = data; we_b = 1'b1; end
      else begin addr_a = addr; wd_a = data[7:0]; we_a = 1'b1; end
      cycles(1);
      we_a = 1'b0;
      we_b = 1'b0;
   endtask

   task automatic host_read(input bit sel, input logic [3:0] addr, output logic [8:0] data);
      if (sel) begin addr_b = addr; re_b = 1'b1; end
      else begin addr_a = addr; re_a = 1'b1; end
      cycles(1);
      re_a = 1'b0;
      re_b = 1'b0;
      data = sel ? rd_b : {1'b0, rd_a};
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx_b = v;
      else rx_a = v;
   endtask

   // Drive one frame at DIV clocks per bit; the stop bit is held stop_cyc clocks, then the line idles high.
   task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                             input bit par_en, input logic par_bit, input logic stop_val, input int stop_cyc);
      set_rx(sel, 1'b0);
      cycles(DIV);
      for (int i = 0; i < nbits; i++) begin
         set_rx(sel, data[i]);
         cycles(DIV);
      end
      if (par_en) begin
         set_rx(sel, par_bit);
         cycles(DIV);
      end
      set_rx(sel, stop_val);
      cycles(stop_cyc);
      set_rx(sel, 1'b1);
   endtask

   function automatic logic exp_tx(input int c, input int n);
      int f, k;
      logic [7:0] b;
      f = (c - 1) / FRAME;
      k = ((c - 1) % FRAME) / DIV;
      if (f >= n) return 1'b1;
      b = exp_bytes[f];
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   // Cycle 1 is the first clock after the edge that popped the first byte; checks first, middle and last clock of each bit.
   task automatic tx_monitor(input int n);
      for (int c = 1; c <= n * FRAME + DIV; c++) begin
         @(posedge clk);
         #1;
         if ((c - 1) % DIV == 0 || (c - 1) % DIV == DIV / 2 || (c - 1) % DIV == DIV - 1)
            check($sformatf("tx_line c=%0d", c), {31'b0, tx_a}, {31'b0, exp_tx(c, n)});
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      rx_a = 1'b1; re_a = 1'b0; we_a = 1'b0; addr_a = '0; wd_a = '0;
      rx_b = 1'b1; re_b = 1'b0; we_b = 1'b0; addr_b = '0; wd_b = '0;
      cycles(3);
      check("reset_tx_a", {31'b0, tx_a}, 32'd1);
      check("reset_rdata_a", {24'b0, rd_a}, 32'd0);
      check("reset_irq_a", {31'b0, irq_a}, 32'd0);
      check("reset_tx_b", {31'b0, tx_b}, 32'd1);
      rst_n = 1'b1;
      cycles(2);

      // Host port basics
      host_read(0, A_ST, rv);  check("idle_status", {23'b0, rv}, 32'h004);
      host_read(0, 4'd7, rv);  check("unmapped_read_holds", {23'b0, rv}, 32'h004);
      host_read(0, A_RX, rv);  check("empty_rx_read", {23'b0, rv}, 32'h000);
      host_write(0, 4'd9, 9'h0FF);
      cycles(2);
      check("unmapped_write_tx_idle", {31'b0, tx_a}, 32'd1);
      host_read(0, A_ST, rv);  check("unmapped_write_status", {23'b0, rv}, 32'h004);

      // Single frame 0xA5 with a status read mid-frame
      exp_bytes[0] = 8'hA5;
      host_write(0, A_TX, 9'h0A5);
      fork
         tx_monitor(1);
         begin
            cycles(100);
            host_read(0, A_ST, rv);
            check("status_busy", {23'b0, rv}, 32'h014);
         end
      join
      host_read(0, A_ST, rv);  check("status_after_frame", {23'b0, rv}, 32'h004);

      // Five back-to-back writes, sixth overflows, five contiguous frames
      exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
      exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h55;
      host_write(0, A_TX, 9'h011);
      fork
         tx_monitor(5);
         begin
            for (int i = 1; i < 5; i++) host_write(0, A_TX, {1'b0, exp_bytes[i]});
            host_write(0, A_TX, 9'h066);
            host_read(0, A_ST, rv);
            check("tx_overflow_status", {23'b0, rv}, 32'h058);
            host_read(0, A_ST, rv);
            check("tx_overflow_cleared", {23'b0, rv}, 32'h018);
         end
      join
      host_read(0, A_ST, rv);  check("tx_drained_status", {23'b0, rv}, 32'h004);

      // RX 0x3C: irq only after the stop-bit sample, read pops it
      send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 20);
      check("irq_before_stop_sample", {31'b0, irq_a}, 32'd0);
      cycles(28);
      check("irq_after_stop_sample", {31'b0, irq_a}, 32'd1);
      host_read(0, A_RX, rv);  check("rx_data_3c", {23'b0, rv}, 32'h03C);
      check("irq_after_pop", {31'b0, irq_a}, 32'd0);

      // Frame error: stop bit low, line held low (break) then released
      send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, DIV + 100);
      cycles(10);
      check("irq_frame_err", {31'b0, irq_a}, 32'd1);
      host_read(0, A_ST, rv);  check("frame_err_status", {23'b0, rv}, 32'h084);
      host_read(0, A_ST, rv);  check("frame_err_cleared", {23'b0, rv}, 32'h004);

      // Overrun: four frames fill RX, fifth dropped
      for (int i = 0; i < 5; i++) send_frame(0, 9'h010 + 9'(i), 8, 1'b0, 1'b0, 1'b1, DIV);
      host_read(0, A_ST, rv);  check("overrun_status", {23'b0, rv}, 32'h027);
      for (int i = 0; i < 4; i++) begin
         host_read(0, A_RX, rv);
         check($sformatf("overrun_order%0d", i), {23'b0, rv}, 32'h010 + i);
      end
      host_read(0, A_ST, rv);  check("overrun_drained", {23'b0, rv}, 32'h004);

      // Same again but the host pops on the push edge of the fifth frame
      for (int i = 0; i < 4; i++) send_frame(0, 9'h020 + 9'(i), 8, 1'b0, 1'b0, 1'b1, DIV);
      fork
         send_frame(0, 9'h024, 8, 1'b0, 1'b0, 1'b1, DIV);
         begin
            cycles(3 + DIV / 2 + 9 * DIV - 1);
            host_read(0, A_RX, rv);
            check("pop_on_push_head", {23'b0, rv}, 32'h020);
         end
      join
      host_read(0, A_ST, rv);  check("no_overrun_status", {23'b0, rv}, 32'h007);
      for (int i = 1; i < 5; i++) begin
         host_read(0, A_RX, rv);
         check($sformatf("pop_on_push_order%0d", i), {23'b0, rv}, 32'h020 + i);
      end

      // Even parity, 9-bit instance
      send_frame(1, 9'h001, 9, 1'b1, 1'b0, 1'b1, DIV);
      check("irq_parity_err", {31'b0, irq_b}, 32'd1);
      host_read(1, A_ST, rv);  check("parity_err_status", {23'b0, rv}, 32'h104);
      host_read(1, A_ST, rv);  check("parity_err_cleared", {23'b0, rv}, 32'h004);
      send_frame(1, 9'h001, 9, 1'b1, 1'b1, 1'b1, DIV);
      host_read(1, A_RX, rv);  check("parity_good_data", {23'b0, rv}, 32'h001);
      host_write(1, A_TX, 9'h001);
      cycles(1 + 9 * DIV + DIV / 2 - 1);
      check("tx_b_data_bit8", {31'b0, tx_b}, 32'd0);
      cycles(DIV);
      check("tx_b_parity_bit", {31'b0, tx_b}, 32'd1);
      cycles(DIV);
      check("tx_b_stop_bit", {31'b0, tx_b}, 32'd1);
      cycles(DIV);

      // Glitch shorter than half a bit is ignored
      rx_a = 1'b0;
      cycles(10);
      rx_a = 1'b1;
      cycles(100);
      host_read(0, A_ST, rv);  check("glitch_no_push", {23'b0, rv}, 32'h004);

      // Reset in the middle of a TX frame and an RX frame
      host_write(0, A_TX, 9'h000);
      rx_a = 1'b0;
      cycles(200);
      check("tx_low_before_reset", {31'b0, tx_a}, 32'd0);
      #2 rst_n = 1'b0;
      #1 check("tx_high_in_reset", {31'b0, tx_a}, 32'd1);
      rx_a = 1'b1;
      cycles(3);
      rst_n = 1'b1;
      cycles(2);
      host_read(0, A_ST, rv);  check("status_after_reset", {23'b0, rv}, 32'h004);
      check("irq_after_reset", {31'b0, irq_a}, 32'd0);
      cycles(DIV);
      check("tx_idle_after_reset", {31'b0, tx_a}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
